// File: rtl/dso_pkg.sv
// Shared DSO_dig definitions: channel encodings, dump FSM states, default
// capture depth and the command processor's DUMP_CH opcode.
package dso_pkg;
  localparam int DEPTH_DEF  = 512;
  localparam int ADDR_W_DEF = 9;

  localparam logic [7:0] OP_DUMP_CH = 8'h01;

  typedef enum logic [1:0] {
    CH1    = 2'b00,
    CH2    = 2'b01,
    CH3    = 2'b10,
    CH_INV = 2'b11
  } ch_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    CAL,
    SEND,
    WAIT_TX
  } dump_st_e;
endpackage

// File: rtl/cal_sat.sv
// Sample calibration datapath: add signed offset, clamp to a byte, apply the
// Q1.7 gain and saturate when the product reaches 2.0.
module cal_sat (
  input  logic [7:0] i_raw,
  input  logic [7:0] i_offset,
  input  logic [7:0] i_gain,
  output logic [7:0] o_result
);
  logic signed [9:0] w_sum;
  logic        [7:0] w_clamp;
  logic       [15:0] w_prod;

  assign w_sum = $signed({2'b00, i_raw}) + $signed({{2{i_offset[7]}}, i_offset});

  // Sum spans -128..382: bit 9 flags negative, bit 8 flags above 255.
  always_comb begin
    w_clamp = w_sum[7:0];
    if (w_sum[9])      w_clamp = 8'h00;
    else if (w_sum[8]) w_clamp = 8'hFF;
  end

  assign w_prod   = {8'h00, w_clamp} * {8'h00, i_gain};
  assign o_result = w_prod[15] ? 8'hFF : w_prod[14:7];
endmodule

// File: rtl/dump_ch_ctrl.sv
// Channel dump engine: walks one capture RAM circularly from the oldest
// sample, calibrates each byte and hands it to the UART one at a time.
module dump_ch_ctrl
  import dso_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        ch_sel,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        cal_offset,
  input  logic [7:0]        cal_gain,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [7:0]        ch1_rdata,
  input  logic [7:0]        ch2_rdata,
  input  logic [7:0]        ch3_rdata,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              err
);
  dump_st_e          r_state, w_nxt;
  ch_sel_e           r_ch;
  logic [ADDR_W-1:0] r_addr, r_cnt;
  logic [7:0]        r_off, r_gain, r_raw, r_tx_data;
  logic              r_done, r_err;
  logic [7:0]        w_rdata, w_cal;
  logic              w_last;

  assign w_last = (r_cnt == ADDR_W'(DEPTH - 1));

  always_comb begin
    case (r_ch)
      CH1:     w_rdata = ch1_rdata;
      CH2:     w_rdata = ch2_rdata;
      default: w_rdata = ch3_rdata;
    endcase
  end

  cal_sat u_cal (
    .i_raw    (r_raw),
    .i_offset (r_off),
    .i_gain   (r_gain),
    .o_result (w_cal)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start && ch_sel != CH_INV) w_nxt = READ;
      READ:    w_nxt = LATCH;
      LATCH:   w_nxt = CAL;
      CAL:     w_nxt = SEND;
      SEND:    w_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) w_nxt = w_last ? IDLE : READ;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ch      <= CH1;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_off     <= '0;
      r_gain    <= '0;
      r_raw     <= '0;
      r_tx_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (ch_sel == CH_INV) r_err <= 1'b1;
          else begin
            r_ch   <= ch_sel_e'(ch_sel);
            r_addr <= start_addr;
            r_cnt  <= '0;
            r_off  <= cal_offset;
            r_gain <= cal_gain;
          end
        end
        LATCH:   r_raw     <= w_rdata;
        CAL:     r_tx_data <= w_cal;
        // Address wraps naturally because DEPTH is a power of two.
        WAIT_TX: if (tx_done) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt + ADDR_W'(1);
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = r_addr;
  assign ram_rd_en = (r_state == READ);
  assign trmt      = (r_state == SEND);
  assign busy      = (r_state != IDLE);
  assign tx_data   = r_tx_data;
  assign done      = r_done;
  assign err       = r_err;
endmodule
